// File: rtl/dnn_matvec_accel.sv
// dnn_matvec_accel: Avalon-MM matrix-vector engine, y[r] = bias[r] + sum_i W[r][i]*x[i].
// Operands are fetched one word at a time over the Avalon master (one outstanding read),
// each y[r] is written back to memory, and the CPU programs jobs through the Avalon slave.
// Optional feature macro: DNN_RELU_EN (ctrl[0] clamps negative results to zero).
module dnn_matvec_accel #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  // CPU register port
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [DATA_W-1:0] slave_readdata,
  input  logic              slave_write,
  input  logic [DATA_W-1:0] slave_writedata,
  // memory port
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_BIAS, S_RD_W, S_RD_X, S_MAC, S_WR_OUT, S_NEXT, S_DONE
  } state_t;

  state_t r_state;

  // programmed registers
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_bias_base;
  logic [DATA_W-1:0] r_w_base;
  logic [DATA_W-1:0] r_x_base;
  logic [DATA_W-1:0] r_out_base;
  logic [DATA_W-1:0] r_len;
  logic [DATA_W-1:0] r_rows;
`ifdef DNN_RELU_EN
  logic              r_relu;
`endif

  // working copies for the running job
  logic [ADDR_W-1:0] r_bias_ptr;
  logic [ADDR_W-1:0] r_w_ptr;
  logic [ADDR_W-1:0] r_x_ptr;
  logic [ADDR_W-1:0] r_x_start;
  logic [ADDR_W-1:0] r_out_ptr;
  logic [DATA_W-1:0] r_len_job;
  logic [DATA_W-1:0] r_len_cnt;
  logic [DATA_W-1:0] r_rows_left;
  logic              r_rd_pend;
  logic              r_wr_pend;

  // datapath
  logic signed [DATA_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]   r_w_val;
  logic signed [DATA_W-1:0]   r_x_val;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [DATA_W-1:0]   w_mac;
  logic [DATA_W-1:0]          w_y;
  logic                       w_reg_wr;

  // CPU accesses stall for the whole job; a held access completes once back in IDLE
  assign slave_waitrequest = (r_state != S_IDLE) && (slave_read || slave_write);
  assign w_reg_wr          = slave_write && (r_state == S_IDLE);

  // Full-precision product, rescaled back to the Q format (wraps, no saturation)
  assign w_prod = r_w_val * r_x_val;
  assign w_mac  = DATA_W'(w_prod >>> FRAC_BITS);

`ifdef DNN_RELU_EN
  assign w_y = (r_relu && r_acc[DATA_W-1]) ? '0 : r_acc;
`else
  assign w_y = r_acc;
`endif

  // Register file: configuration words 1..7, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bias_base <= '0;
      r_w_base    <= '0;
      r_x_base    <= '0;
      r_out_base  <= '0;
      r_len       <= '0;
      r_rows      <= '0;
`ifdef DNN_RELU_EN
      r_relu      <= 1'b0;
`endif
    end else if (w_reg_wr) begin
      case (slave_address)
        4'd1: r_bias_base <= slave_writedata;
        4'd2: r_w_base    <= slave_writedata;
        4'd3: r_x_base    <= slave_writedata;
        4'd4: r_out_base  <= slave_writedata;
        4'd5: r_len       <= slave_writedata;
        4'd6: r_rows      <= slave_writedata;
`ifdef DNN_RELU_EN
        4'd7: r_relu      <= slave_writedata[0];
`endif
        default: ;
      endcase
    end
  end

  // Read-back mux: word 0 returns the last result written to memory
  always_comb begin
    slave_readdata = '0;
    case (slave_address)
      4'd0: slave_readdata = r_result;
      4'd1: slave_readdata = r_bias_base;
      4'd2: slave_readdata = r_w_base;
      4'd3: slave_readdata = r_x_base;
      4'd4: slave_readdata = r_out_base;
      4'd5: slave_readdata = r_len;
      4'd6: slave_readdata = r_rows;
`ifdef DNN_RELU_EN
      4'd7: slave_readdata = {{(DATA_W-1){1'b0}}, r_relu};
`endif
      default: slave_readdata = '0;
    endcase
  end

  // Job sequencer: bias, then (W, x, MAC) per element, then writeback, per row
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_result         <= '0;
      r_bias_ptr       <= '0;
      r_w_ptr          <= '0;
      r_x_ptr          <= '0;
      r_x_start        <= '0;
      r_out_ptr        <= '0;
      r_len_job        <= '0;
      r_len_cnt        <= '0;
      r_rows_left      <= '0;
      r_rd_pend        <= 1'b0;
      r_wr_pend        <= 1'b0;
      r_acc            <= '0;
      r_w_val          <= '0;
      r_x_val          <= '0;
      master_address   <= '0;
      master_read      <= 1'b0;
      master_write     <= 1'b0;
      master_writedata <= '0;
    end else begin
      // read command is held until accepted, then we wait for its data
      if (master_read && !master_waitrequest) begin
        master_read <= 1'b0;
        r_rd_pend   <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (slave_write && slave_address == 4'd0) begin
            r_bias_ptr  <= ADDR_W'(r_bias_base);
            r_w_ptr     <= ADDR_W'(r_w_base);
            r_x_start   <= ADDR_W'(r_x_base);
            r_out_ptr   <= ADDR_W'(r_out_base);
            r_len_job   <= r_len;
            r_rows_left <= r_rows;
            if (r_rows == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state        <= S_RD_BIAS;
              master_read    <= 1'b1;
              master_address <= ADDR_W'(r_bias_base);
            end
          end
        end
        S_RD_BIAS: begin
          if (r_rd_pend && master_readdatavalid) begin
            r_rd_pend <= 1'b0;
            r_acc     <= master_readdata;
            r_x_ptr   <= r_x_start;
            r_len_cnt <= r_len_job;
            if (r_len_job == '0) begin
              r_state <= S_WR_OUT;
            end else begin
              r_state        <= S_RD_W;
              master_read    <= 1'b1;
              master_address <= r_w_ptr;
            end
          end
        end
        S_RD_W: begin
          if (r_rd_pend && master_readdatavalid) begin
            r_rd_pend      <= 1'b0;
            r_w_val        <= master_readdata;
            r_w_ptr        <= r_w_ptr + STRIDE;
            r_state        <= S_RD_X;
            master_read    <= 1'b1;
            master_address <= r_x_ptr;
          end
        end
        S_RD_X: begin
          if (r_rd_pend && master_readdatavalid) begin
            r_rd_pend <= 1'b0;
            r_x_val   <= master_readdata;
            r_x_ptr   <= r_x_ptr + STRIDE;
            r_state   <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc     <= r_acc + w_mac;
          r_len_cnt <= r_len_cnt - DATA_W'(1);
          if (r_len_cnt == DATA_W'(1)) begin
            r_state <= S_WR_OUT;
          end else begin
            r_state        <= S_RD_W;
            master_read    <= 1'b1;
            master_address <= r_w_ptr;
          end
        end
        S_WR_OUT: begin
          // first cycle presents the write; it is then held until accepted
          if (!r_wr_pend) begin
            r_wr_pend        <= 1'b1;
            master_write     <= 1'b1;
            master_writedata <= w_y;
            master_address   <= r_out_ptr;
          end else if (!master_waitrequest) begin
            r_wr_pend   <= 1'b0;
            master_write <= 1'b0;
            r_result    <= master_writedata;
            r_out_ptr   <= r_out_ptr + STRIDE;
            r_bias_ptr  <= r_bias_ptr + STRIDE;
            r_rows_left <= r_rows_left - DATA_W'(1);
            r_state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_rows_left == '0) begin
            r_state <= S_DONE;
          end else begin
            r_state        <= S_RD_BIAS;
            master_read    <= 1'b1;
            master_address <= r_bias_ptr;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_matvec_accel.sv
// tb_dnn_matvec_accel: directed vectors for the matrix-vector engine with a simple
// Avalon memory model (configurable command stall and read latency).
module tb_dnn_matvec_accel;

  logic        clk = 1'b0;
  logic        rst;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  always #5 clk = ~clk;

  dnn_matvec_accel #(.DATA_W(32), .FRAC_BITS(16), .ADDR_W(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:511];
  int          cfg_stall = 0;
  int          cfg_lat   = 1;
  int          stall_cnt = 0;
  int          stall_events = 0;
  int          stall_viol = 0;
  logic        prev_stalled = 1'b0;
  logic        prev_rd = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] rd_log [0:255];
  int          rd_cnt = 0;
  logic [31:0] wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];
  int          wr_cnt = 0;

  assign master_waitrequest = (master_read || master_write) && (stall_cnt < cfg_stall);

  initial begin
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
  end

  always @(posedge clk) begin
    master_readdatavalid <= 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        master_readdatavalid <= 1'b1;
        master_readdata      <= pend_data;
        pend                 <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
    if (prev_stalled) begin
      if (!(master_read || master_write) || master_read != prev_rd || master_address != prev_addr)
        stall_viol <= stall_viol + 1;
    end
    prev_stalled <= (master_read || master_write) && master_waitrequest;
    prev_rd      <= master_read;
    prev_addr    <= master_address;
    if ((master_read || master_write) && master_waitrequest) begin
      stall_cnt    <= stall_cnt + 1;
      stall_events <= stall_events + 1;
    end else begin
      stall_cnt <= 0;
    end
    if (master_read && !master_waitrequest) begin
      if (rd_cnt < 256) rd_log[rd_cnt] <= master_address;
      rd_cnt <= rd_cnt + 1;
      if (cfg_lat <= 1) begin
        master_readdatavalid <= 1'b1;
        master_readdata      <= mem[master_address[10:2]];
      end else begin
        pend      <= 1'b1;
        pend_cnt  <= cfg_lat - 2;
        pend_data <= mem[master_address[10:2]];
      end
    end
    if (master_write && !master_waitrequest) begin
      if (wr_cnt < 64) begin
        wr_addr_log[wr_cnt] <= master_address;
        wr_data_log[wr_cnt] <= master_writedata;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // one slave transfer, held until waitrequest drops (bounded)
  task automatic slv(input bit wr, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] q, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    slave_address   = a;
    slave_write     = wr;
    slave_read      = !wr;
    slave_writedata = d;
    #1;
    while (slave_waitrequest && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = !slave_waitrequest;
    q  = slave_readdata;
    @(posedge clk);
    #1;
    slave_write = 1'b0;
    slave_read  = 1'b0;
  endtask

  typedef struct {
    logic [31:0] bias, wb, xb, ob, len, rows, ctrl, y0, y1;
  } vec_t;

  vec_t vec [0:4];

  task automatic prog(input vec_t v, output bit ok);
    logic [31:0] q;
    bit o;
    ok = 1'b1;
    slv(1'b1, 4'd1, v.bias, q, o); ok &= o;
    slv(1'b1, 4'd2, v.wb,   q, o); ok &= o;
    slv(1'b1, 4'd3, v.xb,   q, o); ok &= o;
    slv(1'b1, 4'd4, v.ob,   q, o); ok &= o;
    slv(1'b1, 4'd5, v.len,  q, o); ok &= o;
    slv(1'b1, 4'd6, v.rows, q, o); ok &= o;
    slv(1'b1, 4'd7, v.ctrl, q, o); ok &= o;
  endtask

  task automatic run_job(input vec_t v, output logic [31:0] res, output bit ok);
    logic [31:0] q;
    bit o;
    prog(v, ok);
    slv(1'b1, 4'd0, 32'd0, q, o); ok &= o;
    slv(1'b0, 4'd0, 32'd0, res, o); ok &= o;
  endtask

  // compare the accepted read addresses against the expected fetch order
  task automatic check_reads(input string nm, input vec_t v, input int base);
    int k, bad;
    logic [31:0] e;
    k = base;
    bad = 0;
    for (int r = 0; r < int'(v.rows); r++) begin
      e = v.bias + 32'(4 * r);
      if (k >= rd_cnt || rd_log[k] !== e) bad++;
      k++;
      for (int i = 0; i < int'(v.len); i++) begin
        e = v.wb + 32'(4 * (r * int'(v.len) + i));
        if (k >= rd_cnt || rd_log[k] !== e) bad++;
        k++;
        e = v.xb + 32'(4 * i);
        if (k >= rd_cnt || rd_log[k] !== e) bad++;
        k++;
      end
    end
    check({nm, "_rd_order_errs"}, 32'(bad), 32'd0);
    check({nm, "_rd_count"}, 32'(rd_cnt - base), v.rows * (32'd1 + 32'd2 * v.len));
  endtask

  task automatic check_writes(input string nm, input vec_t v, input int base);
    logic [31:0] ey;
    check({nm, "_wr_count"}, 32'(wr_cnt - base), v.rows);
    for (int r = 0; r < int'(v.rows) && r < 2; r++) begin
      ey = (r == 0) ? v.y0 : v.y1;
      check($sformatf("%s_y%0d_addr", nm, r), wr_addr_log[base + r], v.ob + 32'(4 * r));
      check($sformatf("%s_y%0d_data", nm, r), wr_data_log[base + r], ey);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] q, res;
    bit ok;
    int rb, wb0, n, ev0, vi0;
    vec_t v;

    for (int i = 0; i < 512; i++) mem[i] = 32'hDEAD0000 + 32'(i);
    // test 1 data
    mem[0]   = 32'h0;        mem[16]  = 32'h00010000; mem[17]  = 32'h00020000;
    mem[32]  = 32'h00030000; mem[33]  = 32'h00008000;
    // test 2 data
    mem[64]  = 32'h0;        mem[65]  = 32'h00010000;
    for (int i = 0; i < 6; i++) mem[80 + i] = 32'(i + 1) << 16;
    for (int i = 0; i < 3; i++) mem[96 + i] = 32'h00010000;
    // test 3 data
    mem[128] = 32'hFFFF0000;
    // signed arithmetic vector: 0.5 + (-1)(1.5) + 2(-0.5) = -2
    mem[192] = 32'h00008000; mem[208] = 32'hFFFF0000; mem[209] = 32'h00020000;
    mem[224] = 32'h00018000; mem[225] = 32'hFFFF8000;
    // wrap + fraction vector: 0x7FFF0000 + 1*1 + 0.5*0.5 wraps to 0x80004000
    mem[256] = 32'h7FFF0000; mem[272] = 32'h00010000; mem[273] = 32'h00008000;
    mem[288] = 32'h00010000; mem[289] = 32'h00008000;

    vec[0] = '{32'h000, 32'h040, 32'h080, 32'h0C0, 32'd2, 32'd1, 32'd0, 32'h00040000, 32'h0};
    vec[1] = '{32'h100, 32'h140, 32'h180, 32'h1C0, 32'd3, 32'd2, 32'd0, 32'h00060000, 32'h00100000};
`ifdef DNN_RELU_EN
    vec[2] = '{32'h200, 32'h210, 32'h220, 32'h240, 32'd0, 32'd1, 32'd1, 32'h00000000, 32'h0};
`else
    vec[2] = '{32'h200, 32'h210, 32'h220, 32'h240, 32'd0, 32'd1, 32'd1, 32'hFFFF0000, 32'h0};
`endif
    vec[3] = '{32'h300, 32'h340, 32'h380, 32'h3C0, 32'd2, 32'd1, 32'd0, 32'hFFFE0000, 32'h0};
    vec[4] = '{32'h400, 32'h440, 32'h480, 32'h4C0, 32'd2, 32'd1, 32'd0, 32'h80004000, 32'h0};

    rst = 1'b1;
    slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_master_read", {31'b0, master_read}, 32'd0);
    check("rst_master_write", {31'b0, master_write}, 32'd0);
    check("rst_waitrequest", {31'b0, slave_waitrequest}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      slv(1'b0, 4'(a), 32'd0, q, ok);
      check($sformatf("rst_word%0d", a), q, 32'd0);
    end

    // table-driven jobs
    for (int i = 0; i < 5; i++) begin
      rb  = rd_cnt;
      wb0 = wr_cnt;
      run_job(vec[i], res, ok);
      $display("job v%0d rows=%0d len=%0d result=%h", i, vec[i].rows, vec[i].len, res);
      check($sformatf("v%0d_done", i), {31'b0, ok}, 32'd1);
      check($sformatf("v%0d_word0", i), res, (vec[i].rows == 2) ? vec[i].y1 : vec[i].y0);
      check_reads($sformatf("v%0d", i), vec[i], rb);
      check_writes($sformatf("v%0d", i), vec[i], wb0);
      slv(1'b0, 4'd5, 32'd0, q, ok);
      check($sformatf("v%0d_len_rb", i), q, vec[i].len);
      slv(1'b0, 4'd7, 32'd0, q, ok);
`ifdef DNN_RELU_EN
      check($sformatf("v%0d_ctrl_rb", i), q, vec[i].ctrl & 32'd1);
`else
      check($sformatf("v%0d_ctrl_rb", i), q, 32'd0);
`endif
    end

    // test 1 again with stalled commands and late read data
    cfg_stall = 3;
    cfg_lat   = 4;
    ev0 = stall_events;
    vi0 = stall_viol;
    rb  = rd_cnt;
    wb0 = wr_cnt;
    run_job(vec[0], res, ok);
    $display("job stalled rows=1 len=2 result=%h", res);
    check("stall_done", {31'b0, ok}, 32'd1);
    check("stall_word0", res, 32'h00040000);
    check_reads("stall", vec[0], rb);
    check_writes("stall", vec[0], wb0);
    check("stall_cycles", 32'(stall_events - ev0), 32'd18);
    check("stall_addr_stable_viol", 32'(stall_viol - vi0), 32'd0);
    cfg_stall = 0;
    cfg_lat   = 1;

    // rows == 0: no traffic, previous result kept
    v = vec[0];
    v.rows = 32'd0;
    rb  = rd_cnt;
    wb0 = wr_cnt;
    run_job(v, res, ok);
    $display("job rows=0 result=%h", res);
    check("rows0_done", {31'b0, ok}, 32'd1);
    check("rows0_word0", res, 32'h00040000);
    check("rows0_reads", 32'(rd_cnt - rb), 32'd0);
    check("rows0_writes", 32'(wr_cnt - wb0), 32'd0);

    // reset in the middle of the first row of test 2
    prog(vec[1], ok);
    rb = rd_cnt;
    slv(1'b1, 4'd0, 32'd0, q, ok);
    n = 0;
    while ((rd_cnt - rb) < 4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_midrow", 32'((rd_cnt - rb) >= 4), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_master_read", {31'b0, master_read}, 32'd0);
    check("abort_master_write", {31'b0, master_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rb  = rd_cnt;
    wb0 = wr_cnt;
    repeat (20) @(negedge clk);
    check("abort_no_reads", 32'(rd_cnt - rb), 32'd0);
    check("abort_no_writes", 32'(wr_cnt - wb0), 32'd0);
    for (int a = 0; a < 8; a++) begin
      slv(1'b0, 4'(a), 32'd0, q, ok);
      check($sformatf("abort_word%0d", a), q, 32'd0);
    end
    rb  = rd_cnt;
    wb0 = wr_cnt;
    run_job(vec[0], res, ok);
    $display("job after abort rows=1 len=2 result=%h", res);
    check("reprog_done", {31'b0, ok}, 32'd1);
    check("reprog_word0", res, 32'h00040000);
    check_writes("reprog", vec[0], wb0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
